regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 104 ++++++++++
 tb/tb_regfile.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- 32 x 32-bit register file with two combinational read ports
// and one synchronous write port, as used between ID (reads) and MEM/WB
// (writeback) in a five-stage pipeline.
//
// Ports
//   clk     in   1   clock; writes land on the rising edge
//   rst     in   1   asynchronous active-high reset; clears every register
//   we      in   1   writeback enable
//   waddr   in   5   writeback register index
//   wdata   in  32   writeback data
//   re1     in   1   read port 1 enable
//   raddr1  in   5   read port 1 register index
//   rdata1  out 32   read port 1 data (combinational)
//   re2     in   1   read port 2 enable
//   raddr2  in   5   read port 2 register index
//   rdata2  out 32   read port 2 data (combinational)
//
// Register 0 is hard-wired to zero: writes to it are dropped and reads of
// it return zero. A read whose index matches the write in the same cycle
// returns wdata so the pipeline sees the value being written back this
// cycle without an extra forwarding stage.
// ---------------------------------------------------------------------------
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic        wr_en_s;

  // A write only takes effect for a non-zero destination outside reset.
  assign wr_en_s = we && (waddr != 5'd0) && !rst;

  // Read-port priority: reset, then enable, then r0, then bypass, then array.
  function automatic logic [31:0] read_port(
    input logic        rst_i,
    input logic        re_i,
    input logic [4:0]  raddr_i,
    input logic        we_i,
    input logic [4:0]  waddr_i,
    input logic [31:0] wdata_i,
    input logic [31:0] stored_i
  );
    logic [31:0] res;
    if (rst_i) begin
      res = 32'h0000_0000;
    end else if (!re_i) begin
      res = 32'h0000_0000;
    end else if (raddr_i == 5'd0) begin
      res = 32'h0000_0000;
    end else if (we_i && (waddr_i == raddr_i)) begin
      res = wdata_i;
    end else begin
      res = stored_i;
    end
    return res;
  endfunction

  // Next-state of the storage array: copy, then overlay the single write.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_s) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d[0] = regs_q[0];
    end
  end

  // Storage array; reset clears every entry immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports, fully independent of each other.
  always_comb begin
    rdata1 = 32'h0000_0000;
    rdata2 = 32'h0000_0000;
    rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
  end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile. A plain array models the
// architectural register contents; expected read data is derived from that
// array and the read-priority rules. Directed scenarios are followed by a
// randomized phase with occasional mid-cycle reset pulses.
// ---------------------------------------------------------------------------
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int          tests_run;
  int          tests_failed;
  logic [31:0] model [32];

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  // 10-unit clock period; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if observed differs from expected.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Expected read data from the architectural state and current inputs.
  function automatic logic [31:0] expect_read(input logic e, input logic [4:0] a);
    if (rst) return 32'h0;
    if (!e) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  // Apply a full set of inputs, then check both ports against the model.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2, input string tag);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    if (r) clear_model();
    #1;
    check_eq({tag, "_p1"}, rdata1, expect_read(re1, raddr1));
    check_eq({tag, "_p2"}, rdata2, expect_read(re2, raddr2));
  endtask

  // Advance one rising edge, commit the write to the model, settle 1 unit.
  task automatic step();
    @(posedge clk);
    if (!rst && we && waddr != 5'd0) model[waddr] = wdata;
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_model();
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;

    // Reset state, including a write attempt held during reset.
    drive(1'b1, 1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd4, 1'b1, 5'd4, "rst_hold");
    step();
    check_eq("rst_wr_ignored", rdata1, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9, "post_rst");
    check_eq("unwritten_zero", rdata1, 32'h0);

    // Reset scenario: r5 = DEADBEEF, then a pulse between edges.
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 5'd5, "wr_r5");
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, "rd_r5");
    check_eq("r5_value", rdata1, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 5'd5, 32'h0BAD_0BAD, 1'b1, 5'd5, 1'b1, 5'd5, "rst_pulse");
    check_eq("r5_during_rst", rdata1, 32'h0);
    #2;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, "rst_after");
    check_eq("r5_after_rst", rdata1, 32'h0);
    step();
    check_eq("r5_after_edge", rdata1, 32'h0);

    // r0 scenario.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, "wr_r0");
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, "rd_r0");
    check_eq("r0_p1", rdata1, 32'h0);
    check_eq("r0_p2", rdata2, 32'h0);

    // Bypass scenario on both ports.
    drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b1, 5'd7, "byp");
    check_eq("byp_p1", rdata1, 32'h1234_5678);
    check_eq("byp_p2", rdata2, 32'h1234_5678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, "byp_after");
    check_eq("byp_after_p1", rdata1, 32'h1234_5678);
    check_eq("byp_after_p2", rdata2, 32'h1234_5678);

    // Enable gating scenario.
    drive(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd0, "wr_r3");
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 5'd3, "re1_off");
    check_eq("re1_off_val", rdata1, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, "re1_on");
    check_eq("re1_on_val", rdata1, 32'hA5A5_A5A5);
    check_eq("re2_off_val", rdata2, 32'h0);

    // Independent ports with a concurrent write elsewhere.
    drive(1'b0, 1'b1, 5'd1, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0, "wr_r1");
    step();
    drive(1'b0, 1'b1, 5'd31, 32'h8000_0000, 1'b0, 5'd0, 1'b0, 5'd0, "wr_r31");
    step();
    drive(1'b0, 1'b1, 5'd2, 32'h0000_0009, 1'b1, 5'd1, 1'b1, 5'd31, "indep");
    check_eq("indep_p1", rdata1, 32'h0000_0001);
    check_eq("indep_p2", rdata2, 32'h8000_0000);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd2, "r2_after");
    check_eq("r2_landed", rdata1, 32'h0000_0009);

    // Sweep: index i holds i * 0x01010101; r0 reads zero.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, i[4:0], i * 32'h0101_0101, 1'b0, 5'd0, 1'b0, 5'd0, "sweep_wr");
      step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, i[4:0], 1'b1, i[4:0], "sweep_rd");
      check_eq("sweep_p1", rdata1, i * 32'h0101_0101);
      check_eq("sweep_p2", rdata2, i * 32'h0101_0101);
    end

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      r  = ($urandom_range(0, 39) == 0);
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(r, 1'($urandom_range(0, 1)), wa, $urandom(),
            ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2, "rnd");
      if (r) begin
        #1;
        drive(1'b0, we, waddr, wdata, re1, raddr1, re2, raddr2, "rnd_rel");
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
